// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bundle: instruction-memory handshake and decoder/datapath side
interface fetch_unit_if;
    // instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    // decoder / datapath side
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic        instr_valid;
    logic        instr_ack;
    logic [1:0]  branch_op;
    logic        alu_zero;
    logic        jr_en;
    logic [31:0] jr_target;
    logic [31:0] pc;

    // fetch unit view
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output instr,
        output opcode,
        output instr_valid,
        input  instr_ack,
        input  branch_op,
        input  alu_zero,
        input  jr_en,
        input  jr_target,
        output pc
    );

    // memory + decoder/datapath view
    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  instr,
        input  opcode,
        input  instr_valid,
        output instr_ack,
        output branch_op,
        output alu_zero,
        output jr_en,
        output jr_target,
        input  pc
    );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - multicycle MIPS instruction fetch: PC, imem handshake, next-PC resolution
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic         clock,
    input  logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic {
        S_REQ  = 1'b0,
        S_HOLD = 1'b1
    } state_t;

    localparam logic [1:0] BR_BEQ = 2'b01;
    localparam logic [1:0] BR_BNE = 2'b10;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        capture;
    logic        advance;

    logic        taken;
    logic [31:0] seq_pc;
    logic [31:0] branch_off;
    logic [31:0] next_pc;

    // state register; reset abandons any outstanding fetch
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_REQ;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode: ready only matters in REQ, ack only in HOLD
    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        advance   = 1'b0;
        case (state)
            S_REQ: begin
                if (bus.imem_ready) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (bus.instr_ack) begin
                    advance   = 1'b1;
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_REQ;
            end
        endcase
    end

    // next-PC resolution from the controls present in the ack cycle; jr outranks branches
    always_comb begin
        taken      = ((bus.branch_op == BR_BEQ) &&  bus.alu_zero) ||
                     ((bus.branch_op == BR_BNE) && !bus.alu_zero);
        seq_pc     = pc_q + 32'd4;
        branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
        if (bus.jr_en) begin
            next_pc = {bus.jr_target[31:2], 2'b00};
        end else if (taken) begin
            next_pc = seq_pc + branch_off;
        end else begin
            next_pc = seq_pc;
        end
    end

    // PC register advances only when the datapath retires the held instruction
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc_q <= {RESET_PC[31:2], 2'b00};
        end else if (advance) begin
            pc_q <= next_pc;
        end
    end

    // instruction register captures the memory word on the ready cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            instr_q <= 32'd0;
        end else if (capture) begin
            instr_q <= bus.imem_rdata;
        end
    end

    // request is masked while reset is held so nothing is issued during reset
    assign bus.imem_req    = (state == S_REQ) && !reset;
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.opcode      = instr_q[31:26];
    assign bus.instr_valid = (state == S_HOLD);
    assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clock = 1'b0;
    logic reset;

    fetch_unit_if bus();

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_pc;
    logic [31:0] model_instr;

    typedef struct {
        logic [31:0] start_pc;
        logic [31:0] word;
        logic [1:0]  bop;
        logic        zero;
        logic        jr;
        logic [31:0] tgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vt[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref_next(input logic [31:0] cur_pc, input logic [31:0] ins,
                                             input logic [1:0] bop, input logic zero,
                                             input logic jr, input logic [31:0] tgt);
        longint off;
        longint sum;
        if (jr) return tgt - (tgt % 32'd4);
        off = longint'($signed(ins[15:0])) * 64'sd4;
        if ((bop == 2'd1 && zero) || (bop == 2'd2 && !zero)) begin
            sum = longint'({32'd0, cur_pc}) + 64'sd4 + off;
            return sum[31:0];
        end
        return cur_pc + 32'd4;
    endfunction

    // called at a negedge with the unit in (or about to be in) REQ
    task automatic fetch(input logic [31:0] word, input int delay, input string tag);
        int          n;
        logic [31:0] a0;
        n = 0;
        while (bus.imem_req !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_req"}, 32'(bus.imem_req), 32'd1);
        chk({tag, "_addr"}, bus.imem_addr, model_pc);
        chk({tag, "_novalid"}, 32'(bus.instr_valid), 32'd0);
        a0 = bus.imem_addr;
        for (int i = 0; i < delay; i++) begin
            bus.imem_ready = 1'b0;
            bus.imem_rdata = $urandom;
            bus.instr_ack  = 1'($urandom_range(0, 1));
            bus.jr_en      = 1'b1;
            bus.jr_target  = $urandom;
            @(negedge clock);
            chk({tag, "_wait_req"}, 32'(bus.imem_req), 32'd1);
            chk({tag, "_wait_addr"}, bus.imem_addr, a0);
            chk({tag, "_wait_pc"}, bus.pc, model_pc);
            chk({tag, "_wait_valid"}, 32'(bus.instr_valid), 32'd0);
        end
        bus.instr_ack  = 1'b0;
        bus.jr_en      = 1'b0;
        bus.imem_ready = 1'b1;
        bus.imem_rdata = word;
        @(negedge clock);
        bus.imem_ready = 1'b0;
        bus.imem_rdata = $urandom;
        model_instr = word;
        chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd1);
        chk({tag, "_instr"}, bus.instr, word);
        chk({tag, "_opcode"}, 32'(bus.opcode), 32'(word[31:26]));
        chk({tag, "_req_off"}, 32'(bus.imem_req), 32'd0);
    endtask

    // called at a negedge in HOLD
    task automatic ack(input logic [1:0] bop, input logic zero, input logic jr,
                       input logic [31:0] tgt, input int hold, input string tag);
        for (int i = 0; i < hold; i++) begin
            bus.instr_ack  = 1'b0;
            bus.imem_ready = 1'b1;
            bus.imem_rdata = $urandom;
            @(negedge clock);
            chk({tag, "_hold_instr"}, bus.instr, model_instr);
            chk({tag, "_hold_valid"}, 32'(bus.instr_valid), 32'd1);
            chk({tag, "_hold_pc"}, bus.pc, model_pc);
        end
        bus.imem_ready = 1'b0;
        bus.branch_op  = bop;
        bus.alu_zero   = zero;
        bus.jr_en      = jr;
        bus.jr_target  = tgt;
        bus.instr_ack  = 1'b1;
        @(negedge clock);
        bus.instr_ack  = 1'b0;
        bus.jr_en      = 1'b0;
        model_pc = ref_next(model_pc, model_instr, bop, zero, jr, tgt);
        chk({tag, "_pc"}, bus.pc, model_pc);
        chk({tag, "_after_valid"}, 32'(bus.instr_valid), 32'd0);
    endtask

    task automatic set_pc(input logic [31:0] target);
        fetch(32'h03E0_0008, 0, "jmp");
        ack(2'd0, 1'b0, 1'b1, target, 0, "jmp");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{32'h40,       32'h1022_FFFF, 2'd1, 1'b1, 1'b0, 32'h0,   32'h40};
        vt[1] = '{32'h40,       32'h1022_FFFF, 2'd1, 1'b0, 1'b0, 32'h0,   32'h44};
        vt[2] = '{32'h40,       32'h1422_0003, 2'd2, 1'b0, 1'b0, 32'h0,   32'h50};
        vt[3] = '{32'h40,       32'h1422_0003, 2'd3, 1'b0, 1'b0, 32'h0,   32'h44};
        vt[4] = '{32'h40,       32'h1422_0003, 2'd2, 1'b1, 1'b0, 32'h0,   32'h44};
        vt[5] = '{32'h40,       32'h03E0_0008, 2'd1, 1'b1, 1'b1, 32'h103, 32'h100};
        vt[6] = '{32'hFFFF_FFFC, 32'h0000_0020, 2'd0, 1'b0, 1'b0, 32'h0,  32'h0};
        vt[7] = '{32'h80,       32'h1000_7FFF, 2'd1, 1'b1, 1'b0, 32'h0,   32'h2_0080};

        bus.imem_ready = 1'b0;
        bus.imem_rdata = 32'd0;
        bus.instr_ack  = 1'b0;
        bus.branch_op  = 2'd0;
        bus.alu_zero   = 1'b0;
        bus.jr_en      = 1'b0;
        bus.jr_target  = 32'd0;
        reset          = 1'b1;

        #12;
        chk("rst_pc", bus.pc, RESET_PC);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_valid", 32'(bus.instr_valid), 32'd0);
        chk("rst_req", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        reset    = 1'b0;
        model_pc = RESET_PC;

        // zero-wait first fetch straight out of reset
        fetch(32'h2008_0005, 0, "first");
        ack(2'd0, 1'b0, 1'b0, 32'd0, 1, "first");

        // directed vectors; first row also exercises a 3-cycle ready delay
        for (int i = 0; i < 8; i++) begin
            set_pc(vt[i].start_pc);
            fetch(vt[i].word, (i == 0) ? 3 : 0, "vec");
            ack(vt[i].bop, vt[i].zero, vt[i].jr, vt[i].tgt, 0, "vec");
            chk("vec_table_pc", bus.pc, vt[i].exp_pc);
        end

        // reset while waiting for ready, with ready arriving under reset
        set_pc(32'h200);
        bus.imem_ready = 1'b0;
        @(negedge clock);
        bus.imem_ready = 1'b1;
        bus.imem_rdata = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        chk("rst_req_async_pc", bus.pc, RESET_PC);
        chk("rst_req_async_req", 32'(bus.imem_req), 32'd0);
        @(negedge clock);
        chk("rst_req_instr", bus.instr, 32'd0);
        chk("rst_req_valid", 32'(bus.instr_valid), 32'd0);
        bus.imem_ready = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("late_ready_instr", bus.instr, 32'd0);
        chk("late_ready_valid", 32'(bus.instr_valid), 32'd0);
        model_pc = RESET_PC;

        // reset coinciding with an ack
        set_pc(32'h300);
        fetch(32'h0000_0000, 0, "rack");
        bus.instr_ack = 1'b1;
        bus.jr_en     = 1'b1;
        bus.jr_target = 32'h500;
        reset = 1'b1;
        @(negedge clock);
        chk("rst_ack_pc", bus.pc, RESET_PC);
        chk("rst_ack_valid", 32'(bus.instr_valid), 32'd0);
        bus.instr_ack = 1'b0;
        bus.jr_en     = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        chk("rst_ack_pc2", bus.pc, RESET_PC);
        model_pc = RESET_PC;

        // randomized traffic against the reference model
        for (int i = 0; i < 40; i++) begin
            logic [31:0] w;
            w = $urandom;
            fetch(w, $urandom_range(0, 3), "rnd");
            ack(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0), $urandom, $urandom_range(0, 2), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
